// File: rtl/instr_mem_ctrl.sv
// Byte-addressed instruction memory: valid/ready fetch port, byte load port, self-clearing init.
// Optional IMEM_PARITY_EN adds per-byte even parity, ld_perr_inject and rsp_perr.
module instr_mem_ctrl #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned ALIGN_CHECK = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0]  rsp_addr,
  output logic               rsp_fault,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [7:0]         ld_data,
`ifdef IMEM_PARITY_EN
  input  logic               ld_perr_inject,
  output logic               rsp_perr,
`endif
  output logic               init_busy
);

  localparam int unsigned NB   = INSTR_W / 8;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MemW = 9;
`else
  localparam int unsigned MemW = 8;
`endif

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     cnt_q, cnt_d;
  logic                clr_we, ld_we, accept;
  logic [MemW-1:0]     mem_q [DEPTH];
  logic [MemW-1:0]     wr_word;

  logic                rd_fault;
  logic [INSTR_W-1:0]  rd_instr;
  logic [ADDR_W-1:0]   rd_idx;
  logic [ADDR_W:0]     rd_last;
  logic                rd_perr;

  logic                rsp_valid_q;
  logic [INSTR_W-1:0]  rsp_instr_q;
  logic [ADDR_W-1:0]   rsp_addr_q;
  logic                rsp_fault_q;
  logic                rsp_perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IdxW'(DEPTH - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun:   ;
      default: state_d = StClear;
    endcase
  end

  assign init_busy = (state_q == StClear);
  assign req_ready = (state_q == StRun) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign ld_we     = (state_q == StRun) && ld_en && ({1'b0, ld_addr} < (ADDR_W + 1)'(DEPTH));

`ifdef IMEM_PARITY_EN
  assign wr_word = {(^ld_data) ^ ld_perr_inject, ld_data};
`else
  assign wr_word = ld_data;
`endif

  // Clear writes win over loads; loads are only legal in StRun anyway.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[cnt_q] <= '0;
      end else if (ld_we) begin
        mem_q[ld_addr[IdxW-1:0]] <= wr_word;
      end
    end
  end

  // Range check in ADDR_W+1 bits so the top of the address space cannot wrap.
  always_comb begin
    rd_last  = {1'b0, req_addr} + (ADDR_W + 1)'(NB - 1);
    rd_fault = (rd_last >= (ADDR_W + 1)'(DEPTH));
    if ((ALIGN_CHECK != 0) && ((req_addr % ADDR_W'(NB)) != '0)) begin
      rd_fault = 1'b1;
    end
    rd_instr = '0;
    rd_idx   = '0;
    rd_perr  = 1'b0;
    if (!rd_fault) begin
      for (int i = 0; i < NB; i++) begin
        rd_idx = req_addr + ADDR_W'(i);
        rd_instr[INSTR_W-1-8*i -: 8] = mem_q[rd_idx[IdxW-1:0]][7:0];
        rd_perr = rd_perr | (^mem_q[rd_idx[IdxW-1:0]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_addr_q  <= '0;
      rsp_fault_q <= 1'b0;
      rsp_perr_q  <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_instr_q <= rd_instr;
      rsp_addr_q  <= req_addr;
      rsp_fault_q <= rd_fault;
      rsp_perr_q  <= (MemW > 8) ? rd_perr : 1'b0;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_fault = rsp_fault_q;
`ifdef IMEM_PARITY_EN
  assign rsp_perr  = rsp_perr_q;
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Randomised scoreboard bench for instr_mem_ctrl: two instances (ALIGN_CHECK 0 and 1) share stimulus.
module tb_instr_mem_ctrl;

  localparam int DEPTH = 128;
  localparam int AW    = 16;
  localparam int IW    = 16;
  localparam int NB    = IW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid, rsp_ready, ld_en;
  logic [AW-1:0] req_addr, ld_addr;
  logic [7:0]    ld_data;

  logic          req_ready0, rsp_valid0, rsp_fault0, init_busy0;
  logic [IW-1:0] rsp_instr0;
  logic [AW-1:0] rsp_addr0;
  logic          req_ready1, rsp_valid1, rsp_fault1, init_busy1;
  logic [IW-1:0] rsp_instr1;
  logic [AW-1:0] rsp_addr1;
`ifdef IMEM_PARITY_EN
  logic          ld_perr_inject = 1'b0;
  logic          rsp_perr0, rsp_perr1;
`endif

  instr_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .INSTR_W(IW), .ALIGN_CHECK(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0), .req_addr(req_addr),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr0), .rsp_addr(rsp_addr0),
    .rsp_fault(rsp_fault0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef IMEM_PARITY_EN
    .ld_perr_inject(ld_perr_inject), .rsp_perr(rsp_perr0),
`endif
    .init_busy(init_busy0)
  );

  instr_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .INSTR_W(IW), .ALIGN_CHECK(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .req_addr(req_addr),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr1), .rsp_addr(rsp_addr1),
    .rsp_fault(rsp_fault1), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef IMEM_PARITY_EN
    .ld_perr_inject(ld_perr_inject), .rsp_perr(rsp_perr1),
`endif
    .init_busy(init_busy1)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
    logic          fault;
  } rsp_t;

  rsp_t       q0[$];
  rsp_t       q1[$];
  logic [7:0] model [DEPTH];
  int         checks = 0;
  int         errors = 0;
  int         clear_left = 0;
  bit         pend = 1'b0;
  bit         armed = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: fault if the last byte lies past DEPTH (no wrap) or, with alignment, a%NB != 0.
  function automatic rsp_t expect_rsp(logic [AW-1:0] a, bit align);
    rsp_t r;
    int   ai;
    ai      = int'(a);
    r.addr  = a;
    r.fault = (ai + NB - 1 >= DEPTH) || (align && (ai % NB != 0));
    r.instr = '0;
    if (!r.fault) begin
      for (int k = 0; k < NB; k++) r.instr = {r.instr[IW-9:0], model[ai+k]};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (armed && !rst && rsp_valid0 === 1'b1) begin
      if (q0.size() == 0) check("dut0_spurious_rsp", q0.size(), 1);
      else begin
        check("dut0_instr", rsp_instr0, q0[0].instr);
        check("dut0_addr", rsp_addr0, q0[0].addr);
        check("dut0_fault", rsp_fault0, q0[0].fault);
`ifdef IMEM_PARITY_EN
        check("dut0_perr", rsp_perr0, 0);
`endif
        if (rsp_ready) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !rst && rsp_valid1 === 1'b1) begin
      if (q1.size() == 0) check("dut1_spurious_rsp", q1.size(), 1);
      else begin
        check("dut1_instr", rsp_instr1, q1[0].instr);
        check("dut1_addr", rsp_addr1, q1[0].addr);
        check("dut1_fault", rsp_fault1, q1[0].fault);
`ifdef IMEM_PARITY_EN
        check("dut1_perr", rsp_perr1, 0);
`endif
        if (rsp_ready) void'(q1.pop_front());
      end
    end
  end

  // One clock: drive just after posedge, decide acceptance from the model at negedge.
  task automatic step(bit v, logic [AW-1:0] a, bit le, logic [AW-1:0] la, logic [7:0] ld, bit rr);
    bit exp_ready;
    bit acc;
    req_valid = v; req_addr = a; ld_en = le; ld_addr = la; ld_data = ld; rsp_ready = rr;
    @(negedge clk);
    exp_ready = (clear_left == 0) && (!pend || rr);
    check("init_busy", init_busy0, (clear_left != 0));
    check("req_ready", req_ready0, exp_ready);
    check("req_ready_dut1", req_ready1, exp_ready);
    acc = v && exp_ready;
    if (acc) begin
      q0.push_back(expect_rsp(a, 1'b0));
      q1.push_back(expect_rsp(a, 1'b1));
    end
    if (le && clear_left == 0 && int'(la) < DEPTH) model[int'(la)] = ld;
    pend = acc || (pend && !rr);
    @(posedge clk);
    if (clear_left > 0) clear_left--;
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 8'h00, 1'b1);
  endtask

  task automatic fetch(logic [AW-1:0] a);
    step(1'b1, a, 1'b0, '0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_left = DEPTH;
    pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    check("rst_rsp_valid", rsp_valid0, 0);
    check("rst_rsp_valid_dut1", rsp_valid1, 0);
    check("rst_rsp_instr", rsp_instr0, 0);
    check("rst_rsp_addr", rsp_addr0, 0);
    check("rst_rsp_fault", rsp_fault0, 0);
    check("rst_init_busy", init_busy0, 1);
  endtask

  logic [7:0] ld_tbl [6] = '{8'h0E, 8'h20, 8'h0B, 8'h21, 8'h23, 8'h45};

  initial begin
    req_valid = 1'b0; req_addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    armed = 1'b1;
    do_reset();
    // Fetch attempts and a load during clear must both be ignored.
    for (int i = 0; i < DEPTH; i++) step((i == 10), '0, (i == DEPTH - 1), '0, 8'h77, 1'b1);
    fetch(16'h0000);
    idle();
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, AW'(i), ld_tbl[i], 1'b1);
    fetch(16'h0000);
    fetch(16'h0002);
    // Back-pressure: response for 2 held three cycles, queued fetch goes on release.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0000, 1'b0, '0, 8'h00, 1'b0);
    step(1'b1, 16'h0000, 1'b0, '0, 8'h00, 1'b1);
    fetch(16'd126);
    fetch(16'd127);
    fetch(16'hFFFF);
    fetch(16'h0001);
    fetch(16'h0003);
    // Same-cycle load and fetch of byte 4: old data first, new data next.
    step(1'b1, 16'h0004, 1'b1, 16'h0004, 8'hAA, 1'b1);
    fetch(16'h0004);
    step(1'b0, '0, 1'b1, 16'd200, 8'h99, 1'b1);
    fetch(16'd72);
    idle();
    repeat (400) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH + 3));
      step(($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, DEPTH + 7)), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, AW'(i), ld_tbl[i], 1'b1);
    idle();
    // Reset while a response is stalled.
    step(1'b1, 16'h0002, 1'b0, '0, 8'h00, 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) idle();
    fetch(16'h0000);
    fetch(16'h0002);
    fetch(16'h0004);
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) idle();
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised, byte-addressed instruction memory with a valid/ready fetch port, a byte-wide program-load port and a self-clearing init sequence.
- Each fetch returns INSTR_W/8 consecutive bytes, big-endian (lowest address = most significant byte), one cycle after the request is accepted.
- Sits between the PC/fetch stage and decode; the load port is driven by the test harness or boot loader.

Parameters:
- DEPTH, 128, memory size in bytes (≥ INSTR_W/8).
- ADDR_W, 16, width of the fetch and load addresses.
- INSTR_W, 16, fetched instruction width; must be a multiple of 8. NB = INSTR_W/8.
- ALIGN_CHECK, 0, when 1 a fetch address not a multiple of NB faults.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  fetch request.
- req_ready  out  1  fetch request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  fetch byte address.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  INSTR_W  fetched instruction.
- rsp_addr  out  ADDR_W  address of the returned instruction.
- rsp_fault  out  1  out-of-range or misaligned fetch.
- ld_en  in  1  byte write strobe.
- ld_addr  in  ADDR_W  byte write address.
- ld_data  in  8  byte write data.
- init_busy  out  1  memory clear in progress.

Behaviour:
- Reset:
  - One clock, clk; synchronous, active-high reset, rst. rst sampled high at a rising edge forces state CLEAR, clear counter = 0, rsp_valid = 0, rsp_instr = 0, rsp_addr = 0, rsp_fault = 0.
  - Reset dominates everything, including mid-clear, mid-fetch and a pending response; the pending response is discarded.
- States:
  - CLEAR: writes 8'h00 to byte[cnt], one byte per cycle, cnt 0..DEPTH-1. init_busy = 1, req_ready = 0, ld_en ignored.
  - After the write of byte DEPTH-1 → RUN. CLEAR lasts exactly DEPTH cycles after rst deasserts.
  - RUN: init_busy = 0. No exit except rst.
- Fetch handshake (RUN only):
  - req_ready = (state == RUN) && (!rsp_valid || rsp_ready). This gives one fetch per cycle at full throughput with no bubble.
  - On accept: at the next edge rsp_valid = 1, rsp_addr = req_addr, rsp_instr = {mem[a], mem[a+1], ..., mem[a+NB-1]}.
  - rsp_valid && !rsp_ready: rsp_instr, rsp_addr and rsp_fault hold stable; req_ready = 0.
  - rsp_valid && rsp_ready with no new accept: rsp_valid → 0 next edge; data fields keep their last value.
- Fault:
  - Condition: a + NB - 1 ≥ DEPTH, evaluated in ADDR_W+1 bits so there is no wrap. Also, when ALIGN_CHECK = 1, a mod NB ≠ 0.
  - Result: rsp_fault = 1, rsp_instr = 0, no memory read. A fault is still a normal response (valid/ready apply).
- Load port:
  - ld_en in RUN with ld_addr < DEPTH writes mem[ld_addr] = ld_data at the edge.
  - ld_addr ≥ DEPTH: write dropped, no side effect.
  - ld_en in CLEAR: dropped.
  - Load and fetch accepted in the same cycle on an overlapping byte: the fetch returns the old (pre-write) byte; the new value is visible to the next fetch.
- Storage:
  - Reg array [7:0] × DEPTH. Read is registered (one-cycle latency); no combinational path from req_addr to rsp_instr.

Optional Feature:
- IMEM_PARITY_EN:
  - When defined: each byte stores an extra even-parity bit, computed on load and clear writes. Adds output rsp_perr (1 bit, reset 0). It is registered with the response: 1 if any fetched byte's stored parity mismatches. A faulted fetch forces rsp_perr = 0.
  - Adds input ld_perr_inject (1 bit): when high with ld_en, the stored parity is inverted (test hook).
  - When not defined: no parity storage; rsp_perr and ld_perr_inject do not exist.

Test Plan:
- Init: pulse rst 1 cycle with DEPTH = 128 → init_busy = 1 for exactly 128 cycles, req_ready = 0 throughout. Then fetch addr 0x0000 → rsp_instr = 16'h0000, rsp_fault = 0.
- Load + fetch: load bytes 0x0E@0, 0x20@1, 0x0B@2, 0x21@3. Fetch 0 then 2 back-to-back with rsp_ready = 1 → responses 16'h0E20 then 16'h0B21 on consecutive cycles; rsp_addr = 0, 2.
- Back-pressure: hold rsp_ready = 0 for 3 cycles after the response for addr 2 → rsp_instr stays 16'h0B21, req_ready = 0. Release → next queued request accepted the same cycle.
- Boundary: fetch 126 → valid, no fault. Fetch 127 → rsp_fault = 1, rsp_instr = 0. Fetch 0xFFFF → fault, no wrap. ALIGN_CHECK = 1, fetch addr 1 → fault.
- Collision: in the same cycle, ld_en to addr 4 with data 0xAA and fetch addr 4 (old byte 0x23) → response high byte 0x23. A following fetch of 4 → high byte 0xAA.
- Reset mid-operation: assert rst while rsp_valid = 1 and rsp_ready = 0 → next edge rsp_valid = 0, init_busy = 1, all previously loaded bytes read 0x00 after CLEAR.
